// File: rtl/db_pkg.sv
// Shared sizing constants for the data buffer store.
package db_pkg;

    localparam int unsigned DB_DEPTH  = 64;
    localparam int unsigned DB_AW     = 6;
    localparam int unsigned DB_PTR_W  = 7;
    localparam int unsigned DB_OCC_W  = 7;
    localparam int unsigned DB_BYTE_W = 8;

    typedef logic [DB_BYTE_W-1:0] db_byte_t;

endpackage : db_pkg

// File: rtl/db_mem.sv
// DEPTH x 8 register file: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module db_mem
    import db_pkg::*;
#(
    parameter int unsigned DEPTH = DB_DEPTH,
    parameter int unsigned AW    = DB_AW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  db_byte_t       wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output db_byte_t       rdata
);

    db_byte_t mem [DEPTH];

    // Storage write; same-cycle read sees the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when not reading.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : db_mem

// File: rtl/db_store.sv
// Byte data buffer: TX/RX write source mux, write pointer, occupancy
// tracking, and overrun/underrun error pulses around a db_mem array.
module db_store
    import db_pkg::*;
#(
    parameter int unsigned DEPTH = DB_DEPTH,
    parameter int unsigned AW    = DB_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store_tx_data,
    input  logic [7:0]           tx_packet_data,
    input  logic                 store_rx_packet_data,
    input  logic [7:0]           rx_packet_data,
    input  logic                 read_en,
    input  logic [DB_PTR_W-1:0]  read_ptr,
    input  logic                 clear,
    input  logic                 flush,
    output logic [DB_OCC_W-1:0]  buff_occ,
    output logic [DB_PTR_W-1:0]  write_ptr,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 overrun,
    output logic                 underrun
);

    logic     wr_req;
    db_byte_t wr_byte;
    logic     wr_ok;
    logic     rd_ok;
    logic     kill;
    logic     mem_we;
    logic     mem_re;
    logic     unused_ptr_bits;

    // Only the low AW bits of the read pointer address the array.
    assign unused_ptr_bits = ^read_ptr[DB_PTR_W-1:AW];

    assign full  = (buff_occ == DB_OCC_W'(DEPTH));
    assign empty = (buff_occ == '0);

    // Request decode: TX wins over RX, full buffer accepts only with a read.
    always_comb begin
        wr_req  = store_tx_data | store_rx_packet_data;
        wr_byte = store_tx_data ? tx_packet_data : rx_packet_data;
        rd_ok   = read_en & ~empty;
        wr_ok   = wr_req & (~full | read_en);
        kill    = clear | flush;
        mem_we  = wr_ok & ~kill & ~rst;
        mem_re  = rd_ok & ~kill;
    end

    // Pointer, occupancy and status register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_ptr <= '0;
            buff_occ  <= '0;
            rd_valid  <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else if (kill) begin
            write_ptr <= '0;
            buff_occ  <= '0;
            rd_valid  <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (wr_ok) begin
                write_ptr <= write_ptr + DB_PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   buff_occ <= buff_occ + DB_OCC_W'(1);
                2'b01:   buff_occ <= buff_occ - DB_OCC_W'(1);
                default: buff_occ <= buff_occ;
            endcase
            rd_valid <= rd_ok;
            overrun  <= wr_req & ~wr_ok;
            underrun <= read_en & empty;
        end
    end

    db_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (write_ptr[AW-1:0]),
        .wdata (wr_byte),
        .re    (mem_re),
        .raddr (read_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule : db_store

// File: tb/tb_db_store.sv
// Self-checking bench for db_store: directed scenarios plus a random
// phase, all compared against a behavioural model of the buffer.
module tb_db_store;
    import db_pkg::*;

    localparam int DEP = DB_DEPTH;

    logic       clk = 1'b0;
    logic       rst;
    logic       store_tx_data, store_rx_packet_data, read_en, clear, flush;
    logic [7:0] tx_packet_data, rx_packet_data;
    logic [6:0] read_ptr;
    logic [6:0] buff_occ, write_ptr;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, overrun, underrun;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [7:0] m_mem [DEP];
    bit         m_known [DEP];
    int         m_wptr, m_occ;
    logic [7:0] m_rd;
    bit         m_rd_known, m_rv, m_ov, m_un;

    db_store dut (
        .clk                  (clk),
        .rst                  (rst),
        .store_tx_data        (store_tx_data),
        .tx_packet_data       (tx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .read_en              (read_en),
        .read_ptr             (read_ptr),
        .clear                (clear),
        .flush                (flush),
        .buff_occ             (buff_occ),
        .write_ptr            (write_ptr),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .full                 (full),
        .empty                (empty),
        .overrun              (overrun),
        .underrun             (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("write_ptr", 32'(write_ptr), 32'(m_wptr));
        chk("buff_occ",  32'(buff_occ),  32'(m_occ));
        chk("full",      32'(full),      32'(m_occ == DEP));
        chk("empty",     32'(empty),     32'(m_occ == 0));
        chk("rd_valid",  32'(rd_valid),  32'(m_rv));
        chk("overrun",   32'(overrun),   32'(m_ov));
        chk("underrun",  32'(underrun),  32'(m_un));
        if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic model(input bit a_rst, input bit a_tx, input logic [7:0] a_txd,
                         input bit a_rx, input logic [7:0] a_rxd, input bit a_re,
                         input logic [6:0] a_rp, input bit a_kill);
        bit wreq, acc, rv;
        int ra, wa;
        if (a_rst) begin
            m_wptr = 0; m_occ = 0; m_rd = 8'h00; m_rd_known = 1'b1;
            m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
            for (int i = 0; i < DEP; i++) m_known[i] = 1'b0;
        end else if (a_kill) begin
            m_wptr = 0; m_occ = 0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            wreq = a_tx | a_rx;
            acc  = wreq && (m_occ < DEP || a_re);
            rv   = a_re && (m_occ > 0);
            ra   = int'(a_rp) % DEP;
            wa   = m_wptr % DEP;
            if (rv) begin
                m_rd       = m_mem[ra];
                m_rd_known = m_known[ra];
            end
            if (acc) begin
                m_mem[wa]   = a_tx ? a_txd : a_rxd;
                m_known[wa] = 1'b1;
                m_wptr      = (m_wptr + 1) % 128;
            end
            m_occ = m_occ + (acc ? 1 : 0) - (rv ? 1 : 0);
            m_ov  = wreq && !acc;
            m_un  = a_re && !rv;
            m_rv  = rv;
        end
    endtask

    task automatic step(input bit a_rst, input bit a_tx, input logic [7:0] a_txd,
                        input bit a_rx, input logic [7:0] a_rxd, input bit a_re,
                        input logic [6:0] a_rp, input bit a_cl, input bit a_fl);
        rst = a_rst; store_tx_data = a_tx; tx_packet_data = a_txd;
        store_rx_packet_data = a_rx; rx_packet_data = a_rxd;
        read_en = a_re; read_ptr = a_rp; clear = a_cl; flush = a_fl;
        @(posedge clk);
        model(a_rst, a_tx, a_txd, a_rx, a_rxd, a_re, a_rp, a_cl | a_fl);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 0, 8'h00, 0, 7'd0, 0, 0);
    endtask

    initial begin
        logic [7:0] first_rx;
        int pw, pr;
        rst = 1'b1; store_tx_data = 0; store_rx_packet_data = 0; read_en = 0;
        clear = 0; flush = 0; tx_packet_data = 0; rx_packet_data = 0; read_ptr = 0;

        // Reset
        step(1, 0, 8'h00, 0, 8'h00, 0, 7'd0, 0, 0);
        step(1, 0, 8'h00, 0, 8'h00, 0, 7'd0, 0, 0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // Three TX writes
        step(0, 1, 8'hA1, 0, 8'h00, 0, 7'd0, 0, 0);
        step(0, 1, 8'hA2, 0, 8'h00, 0, 7'd0, 0, 0);
        step(0, 1, 8'hA3, 0, 8'h00, 0, 7'd0, 0, 0);
        chk("tx3_wptr",  32'(write_ptr), 32'd3);
        chk("tx3_occ",   32'(buff_occ),  32'd3);
        chk("tx3_empty", 32'(empty),     32'd0);

        // Read address 0
        step(0, 0, 8'h00, 0, 8'h00, 1, 7'd0, 0, 0);
        chk("rd0_data",  32'(rd_data),  32'hA1);
        chk("rd0_valid", 32'(rd_valid), 32'd1);
        chk("rd0_occ",   32'(buff_occ), 32'd2);
        idle();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);

        // Fill with 64 RX writes, then one more
        step(0, 0, 8'h00, 0, 8'h00, 0, 7'd0, 1, 0);
        first_rx = 8'($urandom);
        step(0, 0, 8'h00, 1, first_rx, 0, 7'd0, 0, 0);
        for (int i = 1; i < DEP; i++) step(0, 0, 8'h00, 1, 8'($urandom), 0, 7'd0, 0, 0);
        chk("fill_full", 32'(full),      32'd1);
        chk("fill_occ",  32'(buff_occ),  32'd64);
        step(0, 0, 8'h00, 1, 8'hEE, 0, 7'd0, 0, 0);
        chk("ovr_pulse", 32'(overrun),   32'd1);
        chk("ovr_wptr",  32'(write_ptr), 32'd64);
        chk("ovr_occ",   32'(buff_occ),  32'd64);
        idle();
        chk("ovr_clear", 32'(overrun),   32'd0);

        // Full: write 0x55 with read of the same address (read-before-write)
        step(0, 1, 8'h55, 0, 8'h00, 1, 7'd64, 0, 0);
        chk("fullrw_occ",  32'(buff_occ), 32'd64);
        chk("fullrw_ovr",  32'(overrun),  32'd0);
        chk("fullrw_old",  32'(rd_data),  32'(first_rx));
        step(0, 0, 8'h00, 0, 8'h00, 1, 7'd0, 0, 0);
        chk("fullrw_new",  32'(rd_data),  32'h55);

        // Empty read underrun, then TX/RX collision
        step(0, 0, 8'h00, 0, 8'h00, 0, 7'd0, 0, 1);
        step(0, 0, 8'h00, 0, 8'h00, 1, 7'd3, 0, 0);
        chk("udr_pulse", 32'(underrun), 32'd1);
        chk("udr_valid", 32'(rd_valid), 32'd0);
        step(0, 1, 8'h11, 1, 8'h22, 0, 7'd0, 0, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1, 7'd0, 0, 0);
        chk("both_tx", 32'(rd_data), 32'h11);

        // Occupancy 10, flush with concurrent write
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 8'(i + 8'h30), 0, 7'd0, 0, 0);
        chk("occ10", 32'(buff_occ), 32'd10);
        step(0, 1, 8'h77, 0, 8'h00, 1, 7'd2, 0, 1);
        chk("flush_occ",  32'(buff_occ),  32'd0);
        chk("flush_wptr", 32'(write_ptr), 32'd0);
        chk("flush_rv",   32'(rd_valid),  32'd0);

        // Random phase: write-heavy, then read-heavy, with occasional clears/resets
        for (int n = 0; n < 800; n++) begin
            pw = (n % 200 < 100) ? 85 : 30;
            pr = (n % 200 < 100) ? 30 : 80;
            step($urandom_range(299) == 0,
                 $urandom_range(99) < pw, 8'($urandom),
                 $urandom_range(99) < pw, 8'($urandom),
                 $urandom_range(99) < pr, 7'($urandom),
                 $urandom_range(99) == 0, $urandom_range(99) == 0);
        end

        // Reset in the middle of a write and read
        step(0, 1, 8'h5A, 0, 8'h00, 0, 7'd0, 0, 0);
        step(1, 1, 8'h66, 1, 8'h67, 1, 7'd0, 1, 0);
        chk("mrst_wptr",  32'(write_ptr), 32'd0);
        chk("mrst_occ",   32'(buff_occ),  32'd0);
        chk("mrst_rd",    32'(rd_data),   32'd0);
        chk("mrst_rv",    32'(rd_valid),  32'd0);
        chk("mrst_ovr",   32'(overrun),   32'd0);
        chk("mrst_udr",   32'(underrun),  32'd0);
        chk("mrst_full",  32'(full),      32'd0);
        chk("mrst_empty", 32'(empty),     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_db_store

// File: doc/db_store.md
DB_STORE -- requirements
Module: db_store

Interface
REQ-001 Parameter DEPTH, default 64, number of byte entries in the data buffer.
REQ-002 Parameter AW, default 6, storage address width (log2 DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 store_tx_data  input  1  write request, source = host-side TX path.
REQ-006 tx_packet_data  input  8  byte written when store_tx_data accepted.
REQ-007 store_rx_packet_data  input  1  write request, source = USB RX path.
REQ-008 rx_packet_data  input  8  byte written when store_rx_packet_data accepted.
REQ-009 read_en  input  1  read strobe from read block, already registered upstream.
REQ-010 read_ptr  input  7  read pointer from read block; address = read_ptr[AW-1:0].
REQ-011 clear, flush  input  1 each  synchronous buffer reset requests.
REQ-012 buff_occ  output  7  byte count held, 0..64, registered.
REQ-013 write_ptr  output  7  next write pointer, registered.
REQ-014 rd_data  output  8  registered read byte; rd_valid  output  1  qualifies rd_data.
REQ-015 full, empty  output  1 each  buff_occ==64, buff_occ==0, decoded from registers.
REQ-016 overrun, underrun  output  1 each  one-cycle error pulses.

Function
REQ-017 Write request = store_tx_data | store_rx_packet_data; store_tx_data wins when both high, RX byte discarded, no error flagged.
REQ-018 Write accepted when buff_occ<64, or buff_occ==64 with read_en high same cycle.
REQ-019 Accepted write: mem[write_ptr[AW-1:0]] <= selected byte; write_ptr <= write_ptr+1 mod 128.
REQ-020 Rejected write: no storage/pointer/occupancy change; overrun=1 next cycle.
REQ-021 read_en with buff_occ>0: rd_data <= mem[read_ptr[AW-1:0]], rd_valid=1 next cycle (latency 1).
REQ-022 read_en with buff_occ==0: rd_data holds, rd_valid=0, underrun=1 next cycle.
REQ-023 rd_valid 0 in every cycle not following a valid read; rd_data holds last value.
REQ-024 Occupancy: +1 accepted write only; -1 valid read only; unchanged when both or neither.
REQ-025 Write and read same address same cycle: rd_data returns prior contents (read-before-write).
REQ-026 Read pointer direction not interpreted; any read_ptr value accepted, only low AW bits used.
REQ-027 clear or flush: write_ptr<=0, buff_occ<=0, rd_valid<=0, error pulses 0; overrides writes and reads same cycle; storage contents not erased.
REQ-028 buff_occ never exceeds 64 nor wraps below 0.

Reset
REQ-029 rst high at clock edge: write_ptr=0, buff_occ=0, rd_data=0, rd_valid=0, overrun=0, underrun=0; full=0, empty=1.
REQ-030 rst mid-write/read aborts the operation; storage contents undefined after reset, not read before rewrite.
REQ-031 rst has priority over clear, flush and all requests.

Structure
REQ-032 Package db_pkg holds DB_DEPTH=64, DB_AW=6, DB_PTR_W=7, DB_OCC_W=7.
REQ-033 Sub-module db_mem: DEPTH x 8 register file, one write port, one registered read port, no reset on array.
REQ-034 db_store holds pointer, occupancy, source mux, error logic.

Verification
REQ-035 Reset, 3 TX writes 0xA1,0xA2,0xA3 -> write_ptr=3, buff_occ=3, empty=0.
REQ-036 Then read_en with read_ptr=0 -> next cycle rd_data=0xA1, rd_valid=1, buff_occ=2.
REQ-037 64 RX writes from empty, 65th write -> full=1, buff_occ=64, overrun pulse 1 cycle, write_ptr=64.
REQ-038 Full buffer, write 0x55 with read_en same cycle -> accepted, buff_occ stays 64, no overrun.
REQ-039 Empty buffer, read_en -> underrun pulse, rd_valid=0; store_tx_data and store_rx_packet_data together (0x11/0x22) -> 0x11 stored.
REQ-040 buff_occ=10, flush with concurrent write -> buff_occ=0, write_ptr=0, write dropped; rst mid-sequence -> all outputs per REQ-029.
